// File: rtl/pwm_y_decoder.sv
// Servo-style PWM receiver: measures pulse high time in microsecond ticks and
// recovers the 10-bit steering value, with glitch/abort rejection and loss timeout.
module pwm_y_decoder #(
    parameter int unsigned TICK_DIV     = 100,
    parameter int unsigned PULSE_MIN_US = 1000,
    parameter int unsigned GLITCH_US    = 500,
    parameter int unsigned ABORT_US     = 3000,
    parameter int unsigned TIMEOUT_US   = 25000,
    parameter int unsigned Y_RESET      = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [9:0] y_val,
    output logic       y_valid,
    output logic       signal_lost
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_US + 1);

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [15:0]      ABORT_W    = 16'(ABORT_US);
    localparam logic [15:0]      GLITCH_W   = 16'(GLITCH_US);
    localparam logic [16:0]      PMIN_W     = 17'(PULSE_MIN_US);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_US);
    localparam logic [9:0]       Y_RESET_W  = 10'(Y_RESET);

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH,
        EVAL
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [1:0]       fill_q, fill_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] us_pre_q, us_pre_d;
    logic [15:0]      width_q, width_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [9:0]       y_val_q, y_val_d;
    logic             y_valid_q, y_valid_d;
    logic             lost_q, lost_d;

    logic             rise, fall, tick, us_tick, accept;
    logic [16:0]      diff;
    logic [9:0]       y_clamped;

    always_comb begin
        rise    = sync2_q & ~prev_q;
        fall    = ~sync2_q & prev_q;
        tick    = (pre_q == PRE_LAST);
        us_tick = (us_pre_q == PRE_LAST);

        sync1_d = pwm_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fill_d  = {fill_q[0], 1'b1};

        if (rise || tick) pre_d = '0;
        else              pre_d = pre_q + 1'b1;

        if (us_tick) us_pre_d = '0;
        else         us_pre_d = us_pre_q + 1'b1;

        width_d = width_q;
        if (rise)
            width_d = '0;
        else if (state_q == HIGH && tick && width_q < ABORT_W)
            width_d = width_q + 1'b1;

        // 17-bit two's-complement subtraction; bit 16 set means width < PULSE_MIN_US
        diff = {1'b0, width_q} - PMIN_W;
        if (diff[16])               y_clamped = '0;
        else if (diff[15:10] != '0) y_clamped = '1;
        else                        y_clamped = diff[9:0];

        accept = (state_q == EVAL) && (width_q >= GLITCH_W);

        state_d = state_q;
        case (state_q)
            // fill_q guards against the reset value of the synchronizer
            // being mistaken for a real low level
            WAIT_LOW:  if (fill_q[1] && !sync2_q) state_d = WAIT_RISE;
            WAIT_RISE: if (rise) state_d = HIGH;
            HIGH: begin
                if (fall)                    state_d = EVAL;
                else if (width_q >= ABORT_W) state_d = WAIT_LOW;
            end
            EVAL:      state_d = WAIT_RISE;
            default:   state_d = WAIT_LOW;
        endcase

        y_valid_d = accept;
        y_val_d   = accept ? y_clamped : y_val_q;

        to_cnt_d = to_cnt_q;
        lost_d   = lost_q;
        if (accept) begin
            to_cnt_d = '0;
            lost_d   = 1'b0;
        end else if (us_tick && to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_d == TO_LAST) lost_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= WAIT_LOW;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            fill_q    <= '0;
            pre_q     <= '0;
            us_pre_q  <= '0;
            width_q   <= '0;
            to_cnt_q  <= '0;
            y_val_q   <= Y_RESET_W;
            y_valid_q <= 1'b0;
            lost_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            fill_q    <= fill_d;
            pre_q     <= pre_d;
            us_pre_q  <= us_pre_d;
            width_q   <= width_d;
            to_cnt_q  <= to_cnt_d;
            y_val_q   <= y_val_d;
            y_valid_q <= y_valid_d;
            lost_q    <= lost_d;
        end
    end

    assign y_val       = y_val_q;
    assign y_valid     = y_valid_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_pwm_y_decoder.sv
// Scoreboard bench for pwm_y_decoder with a shortened tick and timeout so the
// full scenario list fits in a short run.
module tb_pwm_y_decoder;

    localparam int unsigned TD   = 2;
    localparam int unsigned PMIN = 1000;
    localparam int unsigned GL   = 500;
    localparam int unsigned AB   = 3000;
    localparam int unsigned TO   = 5000;
    localparam int unsigned YR   = 500;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwm_in = 1'b0;
    logic [9:0] y_val;
    logic       y_valid;
    logic       signal_lost;

    pwm_y_decoder #(
        .TICK_DIV    (TD),
        .PULSE_MIN_US(PMIN),
        .GLITCH_US   (GL),
        .ABORT_US    (AB),
        .TIMEOUT_US  (TO),
        .Y_RESET     (YR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .y_val      (y_val),
        .y_valid    (y_valid),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned val;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned last_y = YR;
    int unsigned accept_cyc = 0;

    always @(negedge clk) begin
        if (rst && y_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_y_valid: got strobe with y_val=%0d at cycle %0d, required no strobe", y_val, cyc);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (y_val !== 10'(mon_e.val)) begin
                    errors++;
                    $display("FAIL y_val: got %0d, required %0d", y_val, mon_e.val);
                end
                checks++;
                if (cyc !== mon_e.due) begin
                    errors++;
                    $display("FAIL latency: strobe at cycle %0d, required %0d", cyc, mon_e.due);
                end
                checks++;
                if (signal_lost !== 1'b0) begin
                    errors++;
                    $display("FAIL lost_on_accept: signal_lost=%0b, required 0", signal_lost);
                end
            end
            accept_cyc = cyc;
        end
    end

    task automatic send_pulse(input int unsigned us, input int unsigned low_us);
        int unsigned v;
        @(posedge clk);
        #1 pwm_in = 1'b1;
        repeat (us * TD) @(posedge clk);
        #1 pwm_in = 1'b0;
        if (us >= GL && us < AB) begin
            v = (us <= PMIN) ? 0 : us - PMIN;
            if (v > 1023) v = 1023;
            sb.push_back('{val: v, due: cyc + 4});
            last_y = v;
        end
        repeat (low_us * TD + 8) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_y_valid: %0d pending after %0d us pulse, required 0", sb.size(), us);
        end
        sb.delete();
        checks++;
        if (y_val !== 10'(last_y)) begin
            errors++;
            $display("FAIL y_val_after_%0dus: got %0d, required %0d", us, y_val, last_y);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (y_val !== 10'(YR) || y_valid !== 1'b0 || signal_lost !== 1'b1) begin
            errors++;
            $display("FAIL %s: y_val=%0d y_valid=%0b lost=%0b, required %0d 0 1",
                     tag, y_val, y_valid, signal_lost, YR);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset_initial");
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_nominal();
        send_pulse(1500, 200);
        checks++;
        if (signal_lost !== 1'b0) begin
            errors++;
            $display("FAIL nominal_lost: got %0b, required 0", signal_lost);
        end
    endtask

    task automatic test_clamp();
        send_pulse(900, 50);
        send_pulse(2100, 50);
        send_pulse(1000, 50);
        send_pulse(2000, 50);
    endtask

    task automatic test_rejects();
        send_pulse(300, 50);
        send_pulse(3500, 50);
        send_pulse(1200, 50);
    endtask

    task automatic test_timeout();
        int unsigned lost_cyc;
        bit          seen;
        send_pulse(1500, 20);
        checks++;
        if (signal_lost !== 1'b0) begin
            errors++;
            $display("FAIL lost_early: got %0b, required 0", signal_lost);
        end
        seen = 1'b0;
        lost_cyc = 0;
        for (int i = 0; i < int'((TO + 20) * TD); i++) begin
            @(negedge clk);
            if (signal_lost === 1'b1) begin
                seen = 1'b1;
                lost_cyc = cyc;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_seen: signal_lost=0 after bound, required 1");
        end else begin
            checks++;
            if (lost_cyc - accept_cyc < (TO - 1) * TD + 1 || lost_cyc - accept_cyc > TO * TD) begin
                errors++;
                $display("FAIL timeout_delay: %0d cycles, required %0d..%0d",
                         lost_cyc - accept_cyc, (TO - 1) * TD + 1, TO * TD);
            end
        end
        checks++;
        if (y_val !== 10'(last_y)) begin
            errors++;
            $display("FAIL y_val_on_loss: got %0d, required %0d", y_val, last_y);
        end
        send_pulse(1500, 20);
        checks++;
        if (signal_lost !== 1'b0) begin
            errors++;
            $display("FAIL lost_recover: got %0b, required 0", signal_lost);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            send_pulse($urandom_range(1000, 1400), 10);
    endtask

    task automatic test_reset_mid();
        send_pulse(900, 20);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_reset_outputs("reset_mid_run");
        sb.delete();
        last_y = YR;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_reset_release_high();
        @(posedge clk);
        #1 rst = 1'b0;
        pwm_in = 1'b1;
        repeat (700 * TD) @(posedge clk);
        #1 rst = 1'b1;
        repeat (1050 * TD) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (100 * TD) @(posedge clk);
        #1;
        checks++;
        if (y_val !== 10'(YR)) begin
            errors++;
            $display("FAIL partial_pulse: y_val=%0d, required %0d", y_val, YR);
        end
        send_pulse(1750, 20);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_clamp();
        test_rejects();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_reset_release_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_y_decoder.md
Name: pwm_y_decoder

Overview:
- Receive-side counterpart of the front-wheel steering PWM generator.
- Measures the high time of an incoming servo-style PWM pulse and recovers the 10-bit steering value, so `y_val` = high-time in µs minus PULSE_MIN_US, clamped.
- Used for loopback checking of the steering output and for accepting steering commands from an external RC receiver.
- Sits between a top-level input pin and the steering/SPI logic.

Parameters:
- TICK_DIV, 100, clk cycles per 1 µs measurement tick (100 MHz clk).
- PULSE_MIN_US, 1000, high time mapping to `y_val` = 0.
- GLITCH_US, 500, pulses with high time below this are discarded.
- ABORT_US, 3000, pulses with high time reaching this are discarded.
- TIMEOUT_US, 25000, µs without an accepted pulse before `signal_lost` sets.
- Y_RESET, 500, `y_val` after reset (wheels centred).

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-low reset.
- `pwm_in`  input  1  asynchronous PWM input, high-active pulse.
- `y_val`  output  10  last accepted steering value.
- `y_valid`  output  1  one-clk strobe when `y_val` is updated.
- `signal_lost`  output  1  high while no valid pulse has arrived within TIMEOUT_US.

Behaviour:
- **Reset** (`rst` = 0, asynchronous): `y_val` = Y_RESET, `y_valid` = 0, `signal_lost` = 1. All counters 0, synchronizer FFs 0, FSM = WAIT_LOW.
- **Input path:** `pwm_in` → 2-FF synchronizer → 1 edge-detect register, giving `rise`/`fall` single-cycle flags.
- **Prescaler:** counts 0..TICK_DIV-1 and emits `tick` on wrap. It is cleared on `rise`, so the first tick comes TICK_DIV cycles after the detected edge.
- **Width counter:** 16 bits. Cleared on `rise`, +1 per tick while in HIGH, saturates at ABORT_US.
- **FSM states:**
  - WAIT_LOW: wait for synced input = 0, then go to WAIT_RISE. A pulse already in progress at reset or after an abort is never measured.
  - WAIT_RISE: on `rise` → HIGH.
  - HIGH:
    - on `fall` → EVAL;
    - if width reaches ABORT_US → WAIT_LOW, no update.
  - EVAL (1 cycle):
    - if width < GLITCH_US → WAIT_RISE, no update;
    - else `y_val` <= min(max(width − PULSE_MIN_US, 0), 1023), `y_valid` = 1 for this single cycle, timeout counter cleared, `signal_lost` <= 0, → WAIT_RISE.
- **Arithmetic:** subtraction is done at 17 bits signed. Negative results give 0; results above 1023 give 1023.
- **Latency:** `y_valid` asserts 4 clk cycles after the falling edge of `pwm_in` (2 sync + 1 edge + EVAL register).
- **Timeout:**
  - The µs counter runs on every tick of a free-running µs timebase (a separate prescaler that `rise` does not clear), independent of FSM state.
  - Only an accepted pulse in EVAL clears it.
  - On reaching TIMEOUT_US, `signal_lost` <= 1 and the counter holds.
  - `y_val` keeps its last value and is not forced on loss.
- **Simultaneous events:** if EVAL accepts a pulse in the same cycle the timeout would fire, the accept wins and `signal_lost` stays 0.
- **Reset mid-pulse:** all state clears immediately. After reset release the FSM waits for a low level before measuring.
- **Constraints:** `pwm_in` high/low phases must each be ≥ 3 clk cycles; shorter phases may be missed, with no error reported.

Test Plan:
- **Reset values:** assert `rst` = 0 mid-run → `y_val` = 500, `y_valid` = 0, `signal_lost` = 1 immediately, without a clk edge.
- **Nominal pulse:** 1500 µs high (150000 clk) in a 20 ms period → `y_valid` pulses once 4 clks after the falling edge, `y_val` = 500, `signal_lost` = 0.
- **Clamping:**
  - 900 µs pulse → `y_val` = 0;
  - 2100 µs pulse → `y_val` = 1023 (clamped; 2100 − 1000 = 1100);
  - 1000 µs → 0;
  - 2000 µs → 1000.
- **Rejects:**
  - 300 µs glitch → no `y_valid`, `y_val` unchanged;
  - 3500 µs high → abort, no `y_valid`;
  - next 1200 µs pulse → `y_val` = 200.
- **Timeout:** after one accepted pulse, hold `pwm_in` low 26 ms → `signal_lost` rises 25000 µs after that accept, `y_val` held. The next 1500 µs pulse clears `signal_lost` on the `y_valid` cycle.
- **Reset release during high:** release `rst` while `pwm_in` is high (700 µs into the pulse) → that pulse gives no update. The following full 1750 µs pulse → `y_val` = 750.
